// File: rtl/hilo_muldiv_if.sv
// E-stage HI/LO multiply/divide unit port bundle.
// master = pipeline side, slave = hilo_muldiv.
interface hilo_muldiv_if #(
    parameter int DW = 32
);
    logic          valid_i;
    logic [7:0]    alucontrol_i;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic          flush_i;
    logic          stall_o;
    logic [DW-1:0] result_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    modport master (
        output valid_i, alucontrol_i, a_i, b_i, flush_i,
        input  stall_o, result_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, alucontrol_i, a_i, b_i, flush_i,
        output stall_o, result_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO owner: 1-cycle MULT/MULTU, MTHI/MTLO, MFHI/MFLO and
// a radix-2 restoring DIV/DIVU that stalls the pipeline.
module hilo_muldiv #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            resetn,
    hilo_muldiv_if.slave    bus
);
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, nstate;
    logic [DW-1:0]    hi, lo;
    logic [DW-1:0]    rem, quo, dvs;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, neg_r;
    logic             acc, is_div, sgn, stall;

    logic [2*DW-1:0]  prod_s, prod_u;
    logic [DW-1:0]    abs_a, abs_b;
    logic [DW:0]      rem_sh, diff;
    logic             ge;
    logic [DW-1:0]    q_fix, r_fix;

    assign acc    = bus.valid_i & ~bus.flush_i & (state == IDLE);
    assign is_div = (bus.alucontrol_i == OP_DIV) |
                    (bus.alucontrol_i == OP_DIVU);
    assign sgn    = (bus.alucontrol_i == OP_DIV);

    assign prod_s = {{DW{bus.a_i[DW-1]}}, bus.a_i} *
                    {{DW{bus.b_i[DW-1]}}, bus.b_i};
    assign prod_u = {{DW{1'b0}}, bus.a_i} * {{DW{1'b0}}, bus.b_i};

    assign abs_a = (sgn & bus.a_i[DW-1]) ? -bus.a_i : bus.a_i;
    assign abs_b = (sgn & bus.b_i[DW-1]) ? -bus.b_i : bus.b_i;

    // Partial remainder stays below 2*divisor, so DW+1 bits suffice
    assign rem_sh = {rem, quo[DW-1]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign ge     = ~diff[DW];

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_comb begin
        nstate = state;
        stall  = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc & is_div) begin
                    stall  = 1'b1;
                    nstate = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush_i) begin
                    nstate = IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt == CNT_W'(DW - 1)) nstate = DONE;
                end
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nstate;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi    <= '0;
            lo    <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            if (acc) begin
                case (bus.alucontrol_i)
                    OP_MTHI:  hi <= bus.a_i;
                    OP_MTLO:  lo <= bus.a_i;
                    OP_MULT:  {hi, lo} <= prod_s;
                    OP_MULTU: {hi, lo} <= prod_u;
                    OP_DIV, OP_DIVU: begin
                        quo   <= abs_a;
                        dvs   <= abs_b;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= sgn & (bus.a_i[DW-1] ^ bus.b_i[DW-1]);
                        neg_r <= sgn & bus.a_i[DW-1];
                    end
                    default: ;
                endcase
            end
            if (state == BUSY) begin
                rem <= ge ? diff[DW-1:0] : rem_sh[DW-1:0];
                quo <= {quo[DW-2:0], ge};
                cnt <= cnt + 1'b1;
            end
            if (state == DONE && !bus.flush_i) begin
                hi <= r_fix;
                lo <= q_fix;
            end
        end
    end

    always_comb begin
        bus.result_o = '0;
        case (bus.alucontrol_i)
            OP_MFHI: bus.result_o = hi;
            OP_MFLO: bus.result_o = lo;
            default: ;
        endcase
    end

    assign bus.stall_o = stall;
    assign bus.hi_o    = hi;
    assign bus.lo_o    = lo;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO queued at issue,
// compared when the op retires.
module tb_hilo_muldiv;
    localparam logic [7:0] MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12;
    localparam logic [7:0] MTLO = 8'h13, MULT = 8'h18, MULTU = 8'h19;
    localparam logic [7:0] DIV = 8'h1A, DIVU = 8'h1B;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] m_hi, m_lo;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    hilo_muldiv_if #(.DW(32)) bus ();

    hilo_muldiv #(.DW(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdl(input logic [7:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] ma, mb, uq, ur, q, r;
        longint      ps;
        longint unsigned pu;
        case (op)
            MTHI:  return {a, m_lo};
            MTLO:  return {m_hi, a};
            MULT: begin
                ps = longint'(int'(a)) * longint'(int'(b));
                return ps;
            end
            MULTU: begin
                pu = {32'h0, a} * {32'h0, b};
                return pu;
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            DIV: begin
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                uq = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
                ur = (mb == 0) ? ma : ma % mb;
                q  = (a[31] ^ b[31]) ? -uq : uq;
                r  = a[31] ? -ur : ur;
                return {r, q};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] e;
        int n;
        sb.push_back(mdl(op, a, b));
        {m_hi, m_lo} = sb[$];
        @(negedge clk);
        bus.valid_i      = 1'b1;
        bus.alucontrol_i = op;
        bus.a_i          = a;
        bus.b_i          = b;
        #1;
        if (op == DIV || op == DIVU) begin
            n = 0;
            while (bus.stall_o && n < 100) begin
                n++;
                @(posedge clk);
                #1;
            end
            check("div_stall_cycles", n, 33);
            bus.valid_i = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            check("no_stall", {31'h0, bus.stall_o}, 32'h0);
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
        end
        e = sb.pop_front();
        check("hi", bus.hi_o, e[63:32]);
        check("lo", bus.lo_o, e[31:0]);
    endtask

    initial begin
        logic [31:0] ra, rb;
        resetn           = 1'b0;
        bus.valid_i      = 1'b0;
        bus.flush_i      = 1'b0;
        bus.alucontrol_i = MFHI;
        bus.a_i          = '0;
        bus.b_i          = '0;
        m_hi             = '0;
        m_lo             = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi_o, 32'h0);
        check("rst_lo", bus.lo_o, 32'h0);
        check("rst_stall", {31'h0, bus.stall_o}, 32'h0);
        check("rst_result", bus.result_o, 32'h0);
        resetn = 1'b1;

        run_op(MTHI, 32'h1234_5678, 32'h0);
        @(negedge clk);
        bus.alucontrol_i = MFHI;
        #1 check("mfhi", bus.result_o, 32'h1234_5678);
        bus.alucontrol_i = MFLO;
        #1 check("mflo", bus.result_o, 32'h0);
        bus.alucontrol_i = 8'h00;
        #1 check("other_result", bus.result_o, 32'h0);

        run_op(MULT,  32'hFFFF_FFFE, 32'd3);
        check("mult_hi_k", m_hi, 32'hFFFF_FFFF);
        run_op(MULTU, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_k", m_hi, 32'h0000_0002);

        run_op(DIV,  32'hFFFF_FFF9, 32'd2);
        check("div_lo_k", m_lo, 32'hFFFF_FFFD);
        run_op(DIVU, 32'd100, 32'd7);
        run_op(DIVU, 32'h55, 32'h0);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MTLO, 32'hCAFE_F00D, 32'h0);
        run_op(DIV,  32'd9, 32'h0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 40000);
            run_op((i % 2) ? DIVU : DIV, ra, (i == 2) ? -rb : rb);
        end

        // flush on BUSY cycle 10
        @(negedge clk);
        bus.valid_i      = 1'b1;
        bus.alucontrol_i = DIV;
        bus.a_i          = 32'd1000;
        bus.b_i          = 32'd3;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b0;
        #1 check("flush_stall", {31'h0, bus.stall_o}, 32'h0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_hi", bus.hi_o, m_hi);
        check("flush_lo", bus.lo_o, m_lo);
        repeat (3) @(posedge clk);
        #1 check("flush_hold_lo", bus.lo_o, m_lo);
        run_op(DIV, 32'hFFFF_FF00, 32'd7);

        // reset on BUSY cycle 5
        @(negedge clk);
        bus.valid_i      = 1'b1;
        bus.alucontrol_i = DIVU;
        bus.a_i          = 32'd77;
        bus.b_i          = 32'd5;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        bus.valid_i = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        check("mrst_stall", {31'h0, bus.stall_o}, 32'h0);
        check("mrst_hi", bus.hi_o, 32'h0);
        check("mrst_lo", bus.lo_o, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(DIV, 32'hFFFF_FF9C, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
